// File: rtl/pauli_gate_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pauli_gate_engine
//  Description : Holds a complete NUM_QUBITS-qubit state vector as signed
//                fixed-point (re, im) amplitude pairs and applies an I, X, Y
//                or Z gate to a chosen target qubit, updating one amplitude
//                pair per clock.
//
//  Ports
//    clk                 : clock, all logic on the rising edge
//    rst_n               : synchronous, active-low reset
//    i_wr_en             : host write strobe (honoured only while idle)
//    i_wr_addr           : basis-state index to write
//    i_wr_re, i_wr_im    : amplitude to write
//    i_rd_addr           : basis-state index to read
//    o_rd_re, o_rd_im    : registered read data, one-cycle latency
//    i_start             : single-cycle command strobe
//    i_gate_sel          : 0=I, 1=X, 2=Y, 3=Z, sampled with i_start
//    i_target            : target qubit (index bit position), sampled with i_start
//    o_busy              : high while a gate is in progress (RUN and FIN)
//    o_done              : one-cycle completion pulse
//    o_err               : pulses with o_done when the target is out of range
//
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_BITS
`define FRAC_BITS 8
`endif

module pauli_gate_engine #(
    parameter int  NUM_QUBITS = 3,
    parameter int  DATA_W     = `TOTAL_WIDTH,
    parameter int  FRAC_W     = `FRAC_BITS,
    localparam int ADDR_W     = NUM_QUBITS,
    localparam int TGT_W      = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic signed [DATA_W-1:0] i_wr_re,
    input  logic signed [DATA_W-1:0] i_wr_im,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    output logic signed [DATA_W-1:0] o_rd_re,
    output logic signed [DATA_W-1:0] o_rd_im,
    input  logic                     i_start,
    input  logic [1:0]               i_gate_sel,
    input  logic [TGT_W-1:0]         i_target,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PAIRS = DEPTH / 2;

    localparam logic signed [DATA_W-1:0] c_ONE  = DATA_W'(1 << FRAC_W);
    localparam logic signed [DATA_W-1:0] c_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]        c_LAST = ADDR_W'(PAIRS - 1);

    localparam logic [1:0] c_GATE_X = 2'd1;
    localparam logic [1:0] c_GATE_Y = 2'd2;
    localparam logic [1:0] c_GATE_Z = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                     r_state;
    logic [1:0]                 r_gate;
    logic [TGT_W-1:0]           r_tgt;
    logic [ADDR_W-1:0]          r_k;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_err;
    logic signed [DATA_W-1:0]   r_rd_re;
    logic signed [DATA_W-1:0]   r_rd_im;
    logic signed [DATA_W-1:0]   r_mem_re [DEPTH];
    logic signed [DATA_W-1:0]   r_mem_im [DEPTH];

    logic [ADDR_W-1:0]          w_lo_mask;
    logic [ADDR_W-1:0]          w_tbit;
    logic [ADDR_W-1:0]          w_i;
    logic [ADDR_W-1:0]          w_j;
    logic signed [DATA_W-1:0]   w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [DATA_W-1:0]   w_na_re, w_na_im, w_nb_re, w_nb_im;

    // Two's-complement negation clamped so the most negative code maps to
    // the most positive one instead of wrapping back onto itself.
    function automatic logic signed [DATA_W-1:0] f_neg(input logic signed [DATA_W-1:0] v);
        return (v == c_MIN) ? c_MAX : -v;
    endfunction

    // Pair addressing: i is k with a zero spliced in at the target bit, j is
    // the same index with that bit set. Bits of k below the target stay put,
    // bits at or above it move up by one. k never exceeds PAIRS-1, so the
    // shifted-out top bit is always zero.
    always_comb begin
        w_tbit    = ADDR_W'(1) << r_tgt;
        w_lo_mask = w_tbit - ADDR_W'(1);
        w_i       = ((r_k & ~w_lo_mask) << 1) | (r_k & w_lo_mask);
        w_j       = w_i | w_tbit;
    end

    always_comb begin
        w_a_re  = r_mem_re[w_i];
        w_a_im  = r_mem_im[w_i];
        w_b_re  = r_mem_re[w_j];
        w_b_im  = r_mem_im[w_j];
        w_na_re = w_a_re;
        w_na_im = w_a_im;
        w_nb_re = w_b_re;
        w_nb_im = w_b_im;
        case (r_gate)
            c_GATE_X: begin
                w_na_re = w_b_re;
                w_na_im = w_b_im;
                w_nb_re = w_a_re;
                w_nb_im = w_a_im;
            end
            c_GATE_Y: begin
                w_na_re = w_b_im;
                w_na_im = f_neg(w_b_re);
                w_nb_re = f_neg(w_a_im);
                w_nb_im = w_a_re;
            end
            c_GATE_Z: begin
                w_nb_re = f_neg(w_b_re);
                w_nb_im = f_neg(w_b_im);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gate  <= 2'd0;
            r_tgt   <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd_re <= '0;
            r_rd_im <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                r_mem_re[n] <= '0;
                r_mem_im[n] <= '0;
            end
            // Basis state |0...0> with unit amplitude.
            r_mem_re[0] <= c_ONE;
        end else begin
            r_rd_re <= r_mem_re[i_rd_addr];
            r_rd_im <= r_mem_im[i_rd_addr];
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // A write in the start cycle lands before the first pair
                    // is read, so the gate sees the updated vector.
                    if (i_wr_en) begin
                        r_mem_re[i_wr_addr] <= i_wr_re;
                        r_mem_im[i_wr_addr] <= i_wr_im;
                    end
                    if (i_start) begin
                        r_gate <= i_gate_sel;
                        r_tgt  <= i_target;
                        r_k    <= '0;
                        r_busy <= 1'b1;
                        if (int'(i_target) < NUM_QUBITS) begin
                            r_state <= S_RUN;
                        end else begin
                            // Bad target: skip the sweep, report straight away.
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    r_mem_re[w_i] <= w_na_re;
                    r_mem_im[w_i] <= w_na_im;
                    r_mem_re[w_j] <= w_nb_re;
                    r_mem_im[w_j] <= w_nb_im;
                    r_k           <= r_k + ADDR_W'(1);
                    if (r_k == c_LAST) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end

                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_re = r_rd_re;
    assign o_rd_im = r_rd_im;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pauli_gate_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pauli_gate_engine
//  Description : Directed self-checking bench for pauli_gate_engine with
//                NUM_QUBITS=3, DATA_W=16, FRAC_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pauli_gate_engine;

    localparam int NQ     = 3;
    localparam int DW     = 16;
    localparam int FW     = 8;
    localparam int ONE    = 1 << FW;
    localparam int MAXLAT = 20;

    logic                 clk;
    logic                 rst_n;
    logic                 i_wr_en;
    logic [2:0]           i_wr_addr;
    logic signed [DW-1:0] i_wr_re;
    logic signed [DW-1:0] i_wr_im;
    logic [2:0]           i_rd_addr;
    logic signed [DW-1:0] o_rd_re;
    logic signed [DW-1:0] o_rd_im;
    logic                 i_start;
    logic [1:0]           i_gate_sel;
    logic [1:0]           i_target;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    int n_checks = 0;
    int n_fails  = 0;

    pauli_gate_engine #(
        .NUM_QUBITS (NQ),
        .DATA_W     (DW),
        .FRAC_W     (FW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_re    (i_wr_re),
        .i_wr_im    (i_wr_im),
        .i_rd_addr  (i_rd_addr),
        .o_rd_re    (o_rd_re),
        .o_rd_im    (o_rd_im),
        .i_start    (i_start),
        .i_gate_sel (i_gate_sel),
        .i_target   (i_target),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_amp(input int addr, input int re, input int im);
        i_wr_en   = 1'b1;
        i_wr_addr = 3'(addr);
        i_wr_re   = DW'(re);
        i_wr_im   = DW'(im);
        tick();
        i_wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int re, input int im);
        i_rd_addr = 3'(addr);
        tick();
        check_val($sformatf("%s_e%0d_re", tag, addr), int'(o_rd_re), re);
        check_val($sformatf("%s_e%0d_im", tag, addr), int'(o_rd_im), im);
    endtask

    // Issues a command and counts cycles from the start cycle to done.
    task automatic run_gate(input string tag, input int gate, input int tgt,
                            input int exp_lat, input int exp_err);
        int lat;
        i_start    = 1'b1;
        i_gate_sel = 2'(gate);
        i_target   = 2'(tgt);
        tick();
        i_start = 1'b0;
        lat = 1;
        while (!o_done && lat < MAXLAT) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_err"}, int'(o_err), exp_err);
        check_val({tag, "_busy_at_done"}, int'(o_busy), 1);
        tick();
        check_val({tag, "_done_pulse_len"}, int'(o_done), 0);
        check_val({tag, "_busy_after"}, int'(o_busy), 0);
    endtask

    initial begin
        int lat;
        rst_n      = 1'b0;
        i_wr_en    = 1'b0;
        i_wr_addr  = '0;
        i_wr_re    = '0;
        i_wr_im    = '0;
        i_rd_addr  = '0;
        i_start    = 1'b0;
        i_gate_sel = '0;
        i_target   = '0;
        repeat (3) tick();
        check_val("rst_busy", int'(o_busy), 0);
        check_val("rst_done", int'(o_done), 0);
        check_val("rst_err", int'(o_err), 0);
        check_val("rst_rd_re", int'(o_rd_re), 0);
        rst_n = 1'b1;

        // Reset state of the vector.
        read_chk("rst", 0, ONE, 0);
        for (int a = 1; a < 8; a++) read_chk("rst", a, 0, 0);

        // X on qubit 0.
        write_amp(0, 100, -20);
        write_amp(1, 0, 50);
        run_gate("x_t0", 1, 0, 5, 0);
        read_chk("x_t0", 0, 0, 50);
        read_chk("x_t0", 1, 100, -20);
        for (int a = 2; a < 8; a++) read_chk("x_t0", a, 0, 0);

        // Y on qubit 0.
        write_amp(0, 100, -20);
        write_amp(1, 0, 50);
        run_gate("y_t0", 2, 0, 5, 0);
        read_chk("y_t0", 0, 50, 0);
        read_chk("y_t0", 1, 20, 100);

        // Z on qubit 2 with saturating negation.
        write_amp(4, -32768, 7);
        run_gate("z_t2", 3, 2, 5, 0);
        read_chk("z_t2", 4, 32767, -7);
        read_chk("z_t2", 0, 50, 0);
        read_chk("z_t2", 1, 20, 100);

        // I on qubit 1: full sweep, nothing changes.
        run_gate("i_t1", 0, 1, 5, 0);
        read_chk("i_t1", 4, 32767, -7);
        read_chk("i_t1", 1, 20, 100);

        // Out-of-range target.
        run_gate("bad_tgt", 1, 3, 1, 1);
        read_chk("bad_tgt", 0, 50, 0);
        read_chk("bad_tgt", 4, 32767, -7);

        // X on qubit 1 with a start and a write issued mid-RUN.
        i_start    = 1'b1;
        i_gate_sel = 2'd1;
        i_target   = 2'd1;
        tick();
        i_start = 1'b0;
        tick();
        i_start    = 1'b1;
        i_gate_sel = 2'd2;
        i_target   = 2'd0;
        i_wr_en    = 1'b1;
        i_wr_addr  = 3'd3;
        i_wr_re    = 16'sd111;
        i_wr_im    = 16'sd222;
        tick();
        i_start = 1'b0;
        i_wr_en = 1'b0;
        lat = 3;
        while (!o_done && lat < MAXLAT) begin
            tick();
            lat++;
        end
        check_val("midrun_latency", lat, 5);
        tick();
        check_val("midrun_busy_after", int'(o_busy), 0);
        tick();
        check_val("midrun_no_requeue", int'(o_busy), 0);
        read_chk("midrun", 0, 0, 0);
        read_chk("midrun", 1, 0, 0);
        read_chk("midrun", 2, 50, 0);
        read_chk("midrun", 3, 20, 100);
        read_chk("midrun", 4, 0, 0);
        read_chk("midrun", 6, 32767, -7);

        // Reset asserted during RUN.
        i_start    = 1'b1;
        i_gate_sel = 2'd1;
        i_target   = 2'd0;
        tick();
        i_start = 1'b0;
        tick();
        check_val("abort_busy_before", int'(o_busy), 1);
        rst_n = 1'b0;
        tick();
        check_val("abort_busy", int'(o_busy), 0);
        check_val("abort_done", int'(o_done), 0);
        rst_n = 1'b1;
        read_chk("abort", 0, ONE, 0);
        for (int a = 1; a < 8; a++) read_chk("abort", a, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
